// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared state encodings and constants for the fetch stage
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP      = 32'h0000_0000;

    // J-type target = {pc4[31:28], instr[25:0], 2'b00}
    localparam int JUMP_PC_HI_W = 4;
    localparam int JUMP_IDX_W   = 26;

endpackage

// File: rtl/fetch_unit_add4.sv
// rtl/fetch_unit_add4.sv - 32-bit PC+4 incrementer, wraps modulo 2^32
module fetch_unit_add4 (
    input  logic [31:0] i_a,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + 32'd4;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, IF/ID buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP      = DEFAULT_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inStall,
    input  logic        inBranchTaken,
    input  logic [31:0] inBranchTarget,
    input  logic        inJumpTaken,
    input  logic [31:0] inJumpTarget,
    output logic        outMemReq,
    output logic [31:0] outMemAddr,
    input  logic        inMemReady,
    input  logic [31:0] inMemData,
    output logic [31:0] outAdd,
    output logic [31:0] outInsMem,
    output logic [31:0] outJump,
    output logic        outValid
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend_pc;
    logic [31:0]  r_hold_ins;
    logic [31:0]  r_hold_add;
    logic [31:0]  r_out_ins;
    logic [31:0]  r_out_add;
    logic         r_out_valid;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_pend_pc_nxt;
    logic [31:0]  w_hold_ins_nxt;
    logic [31:0]  w_hold_add_nxt;
    logic [31:0]  w_out_ins_nxt;
    logic [31:0]  w_out_add_nxt;
    logic         w_out_valid_nxt;
    logic [31:0]  w_pc_plus4;
    logic         w_redirect;
    logic [31:0]  w_target;

    fetch_unit_add4 u_add4 (
        .i_a   (r_pc),
        .o_sum (w_pc_plus4)
    );

    assign w_redirect = inBranchTaken | inJumpTaken;
    assign w_target   = inBranchTaken ? inBranchTarget : inJumpTarget;

    assign outMemReq  = (r_state != ST_HOLD);
    assign outMemAddr = r_pc;
    assign outAdd     = r_out_add;
    assign outInsMem  = r_out_ins;
    assign outValid   = r_out_valid;
    assign outJump    = {r_out_add[31 -: JUMP_PC_HI_W], r_out_ins[JUMP_IDX_W-1:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_pend_pc   <= 32'd0;
            r_hold_ins  <= 32'd0;
            r_hold_add  <= 32'd0;
            r_out_ins   <= NOP;
            r_out_add   <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_pc   <= w_pend_pc_nxt;
            r_hold_ins  <= w_hold_ins_nxt;
            r_hold_add  <= w_hold_add_nxt;
            r_out_ins   <= w_out_ins_nxt;
            r_out_add   <= w_out_add_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_pc_nxt   = r_pend_pc;
        w_hold_ins_nxt  = r_hold_ins;
        w_hold_add_nxt  = r_hold_add;
        w_out_ins_nxt   = r_out_ins;
        w_out_add_nxt   = r_out_add;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            ST_FETCH: begin
                if (w_redirect) begin
                    if (inMemReady) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // request already on the bus: let it complete, then retarget
                        w_pend_pc_nxt = w_target;
                        w_state_nxt   = ST_DRAIN;
                    end
                end else if (inMemReady) begin
                    w_pc_nxt = w_pc_plus4;
                    if (!inStall) begin
                        w_out_ins_nxt   = inMemData;
                        w_out_add_nxt   = w_pc_plus4;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_hold_ins_nxt = inMemData;
                        w_hold_add_nxt = w_pc_plus4;
                        w_state_nxt    = ST_HOLD;
                    end
                end else if (!inStall) begin
                    w_out_ins_nxt   = NOP;
                    w_out_valid_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (w_redirect) begin
                    w_pend_pc_nxt = w_target;
                end
                if (inMemReady) begin
                    w_pc_nxt    = w_redirect ? w_target : r_pend_pc;
                    w_state_nxt = ST_FETCH;
                end
                if (!inStall) begin
                    w_out_ins_nxt   = NOP;
                    w_out_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (!inStall) begin
                    w_out_ins_nxt   = r_hold_ins;
                    w_out_add_nxt   = r_hold_add;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // flush overrides stall
        if (w_redirect) begin
            w_out_ins_nxt   = NOP;
            w_out_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory/stall/redirect
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOPW   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inStall = 1'b0;
    logic        inBranchTaken = 1'b0;
    logic [31:0] inBranchTarget = 32'd0;
    logic        inJumpTaken = 1'b0;
    logic [31:0] inJumpTarget = 32'd0;
    logic        outMemReq;
    logic [31:0] outMemAddr;
    logic        inMemReady = 1'b0;
    logic [31:0] inMemData = 32'd0;
    logic [31:0] outAdd;
    logic [31:0] outInsMem;
    logic [31:0] outJump;
    logic        outValid;

    fetch_unit #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
        .clk            (clk),
        .rst            (rst),
        .inStall        (inStall),
        .inBranchTaken  (inBranchTaken),
        .inBranchTarget (inBranchTarget),
        .inJumpTaken    (inJumpTaken),
        .inJumpTarget   (inJumpTarget),
        .outMemReq      (outMemReq),
        .outMemAddr     (outMemAddr),
        .inMemReady     (inMemReady),
        .inMemData      (inMemData),
        .outAdd         (outAdd),
        .outInsMem      (outInsMem),
        .outJump        (outJump),
        .outValid       (outValid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pres  = 0;
    int cycle   = 0;
    int gap_mode = 0;
    int last_pres = -1;
    bit wrap_seen = 1'b0;
    bit mem_rand = 1'b0;
    int mem_wait = 0;

    // expected program-order stream of instruction addresses
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E0F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic restart_stream(input logic [31:0] a);
        exp_q.delete();
        exp_q.push_back(a);
        last_pres = -1;
    endtask

    // memory model: random or fixed wait cycles per request
    bit          busy = 1'b0;
    int          cnt = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    always @(negedge clk) begin
        if (rst) begin
            inMemReady = 1'b0;
            busy = 1'b0;
        end else if (outMemReq) begin
            if (prev_wait) check("addr_stable", outMemAddr, prev_addr);
            if (!busy) begin
                busy = 1'b1;
                cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
            end
            if (cnt == 0) begin
                inMemReady = 1'b1;
                inMemData  = mem_word(outMemAddr);
                busy = 1'b0;
            end else begin
                cnt--;
                inMemReady = 1'b0;
                inMemData  = 32'hDEAD_BEEF;
            end
        end else begin
            inMemReady = 1'b0;
            inMemData  = 32'hDEAD_BEEF;
        end
        prev_wait = !rst && outMemReq && !inMemReady;
        prev_addr = outMemAddr;
    end

    // monitor: a new presentation is an unstalled edge leaving outValid=1
    always @(posedge clk) begin
        logic [31:0] ea;
        logic [31:0] eadd;
        #1;
        cycle++;
        if (!rst && !inStall && outValid) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                if (exp_q.size() == 1) exp_q.push_back(exp_q[0] + 32'd4);
                ea = exp_q.pop_front();
                eadd = ea + 32'd4;
                n_pres++;
                if (ea == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                check("ins", outInsMem, mem_word(ea));
                check("add", outAdd, eadd);
                check("jump", outJump, {eadd[31:28], mem_word(ea) & 32'h03FF_FFFF} << 0 == 0 ?
                      32'd0 : {eadd[31:28], 28'd0} | ({6'd0, mem_word(ea) & 32'h03FF_FFFF} << 2));
                if (gap_mode != 0) begin
                    if (last_pres >= 0) check("gap", cycle - last_pres, gap_mode);
                    last_pres = cycle;
                end
            end
        end
    end

    task automatic drive_point();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic br, input logic [31:0] bt,
                          input logic jp, input logic [31:0] jt);
        inStall = st;
        inBranchTaken = br;
        inBranchTarget = bt;
        inJumpTaken = jp;
        inJumpTarget = jt;
        if (br || jp) restart_stream(br ? bt : jt);
    endtask

    task automatic do_reset(input bit rnd, input int w);
        drive_point();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        mem_rand = rnd;
        mem_wait = w;
        gap_mode = 0;
        drive_point();
        drive_point();
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_ins", outInsMem, NOPW);
        check("rst_add", outAdd, 32'd0);
        check("rst_jump", outJump, 32'd0);
        check("rst_req", {31'd0, outMemReq}, 32'd1);
        check("rst_addr", outMemAddr, RST_PC);
        rst = 1'b0;
        restart_stream(RST_PC);
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive_point();
            if (outMemReq && outMemAddr == a) found = 1'b1;
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        // zero-wait memory: one instruction per cycle
        do_reset(0, 0);
        for (int i = 0; i < 8; i++) begin
            drive_point();
            if (i >= 1) check("zw_valid", {31'd0, outValid}, 32'd1);
        end

        // two wait cycles: two bubbles between instructions
        do_reset(0, 2);
        gap_mode = 3;
        last_pres = -1;
        for (int i = 0; i < 15; i++) drive_point();
        gap_mode = 0;

        // jump while a request is waiting -> drain, refetch at 0x400
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                drive_point();
                if (outMemReq && !inMemReady) got = 1'b1;
            end
            check("wait_seen", {31'd0, got}, 32'd1);
        end
        set_in(0, 0, 0, 1, 32'h0000_0400);
        drive_point();
        check("jmp_flush", {31'd0, outValid}, 32'd0);
        set_in(0, 0, 0, 0, 0);
        wait_addr("jmp_addr", 32'h0000_0400);
        for (int i = 0; i < 8; i++) drive_point();

        // branch and jump together under stall: branch wins, flush overrides stall
        set_in(1, 1, 32'h0000_0100, 1, 32'h0000_0200);
        drive_point();
        check("bj_flush", {31'd0, outValid}, 32'd0);
        set_in(0, 0, 0, 0, 0);
        wait_addr("bj_addr", 32'h0000_0100);
        for (int i = 0; i < 8; i++) drive_point();

        // stall while data returns: hold with no request, held word presented after
        do_reset(0, 0);
        for (int i = 0; i < 4; i++) drive_point();
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_point();
            check("hold_req", {31'd0, outMemReq}, 32'd0);
            check("hold_valid", {31'd0, outValid}, 32'd1);
        end
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive_point();

        // PC wrap-around at the top of the address space
        set_in(0, 0, 0, 1, 32'hFFFF_FFF8);
        drive_point();
        set_in(0, 0, 0, 0, 0);
        wait_addr("wrap_addr", 32'h0000_0000);
        for (int i = 0; i < 4; i++) drive_point();
        check("wrap_seen", {31'd0, wrap_seen}, 32'd1);

        // randomized memory latency, stalls and redirects
        do_reset(1, 0);
        for (int i = 0; i < 800; i++) begin
            logic st;
            logic br;
            logic jp;
            logic [31:0] bt;
            logic [31:0] jt;
            drive_point();
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 19) == 0);
            jp = ($urandom_range(0, 19) == 0);
            bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            jt = $urandom & 32'hFFFF_FFFC;
            set_in(st, br, bt, jp, jt);
        end
        drive_point();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive_point();
        check("pres_count", {31'd0, (n_pres >= 150)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined datapath. Owns the program counter, issues instruction-memory reads over a ready handshake, computes PC+4 and the J-type jump target, and registers the fetched instruction into the IF/ID pipeline buffer. Honours hazard-unit stalls and branch/jump redirects, discarding in-flight or held fetches on redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0000, instruction word driven on bubbles/flush.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- inStall  in  1  hazard-unit stall: hold IF/ID outputs, do not advance PC.
- inBranchTaken  in  1  branch resolved taken (older instruction).
- inBranchTarget  in  32  branch target address.
- inJumpTaken  in  1  jump decoded in ID.
- inJumpTarget  in  32  jump target address.
- outMemReq  out  1  instruction-memory read request (combinational from state).
- outMemAddr  out  32  read address; stable while outMemReq=1 until inMemReady.
- inMemReady  in  1  read data valid this cycle (0 or more wait cycles).
- inMemData  in  32  instruction word.
- outAdd  out  32  PC+4 of the presented instruction.
- outInsMem  out  32  presented instruction.
- outJump  out  32  {outAdd[31:28], outInsMem[25:0], 2'b00}.
- outValid  out  1  outputs hold a real instruction (0 = bubble).

## Operation
- Registers: pc (request address), pendPc (redirect target during drain), holdIns/holdAdd (captured during stall), state.
- Redirect = inBranchTaken | inJumpTaken; target = inBranchTarget if inBranchTaken else inJumpTarget (branch wins).
- States FETCH, DRAIN, HOLD.
- FETCH: outMemReq=1, outMemAddr=pc.
  - redirect & inMemReady: data discarded, pc<=target, stay FETCH.
  - redirect & !inMemReady: pendPc<=target, ->DRAIN.
  - inMemReady & !inStall: outInsMem<=inMemData, outAdd<=pc+4, outJump computed, outValid<=1, pc<=pc+4.
  - inMemReady & inStall: holdIns<=inMemData, holdAdd<=pc+4, pc<=pc+4, ->HOLD; outputs unchanged.
  - !inMemReady & !inStall: outValid<=0, outInsMem<=NOP.
- DRAIN: outMemReq=1, outMemAddr=pc (old). Further redirect overwrites pendPc. On inMemReady: data discarded, pc<=pendPc, ->FETCH.
- HOLD: outMemReq=0. Redirect: held data discarded, pc<=target, ->FETCH. Else !inStall: present holdIns/holdAdd with outValid<=1, ->FETCH.
- Any redirect cycle: outValid<=0, outInsMem<=NOP, regardless of inStall (flush overrides stall).
- inStall with no redirect: outAdd/outInsMem/outJump/outValid hold.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Low two PC bits not checked.

## Timing
- Reset (rst=1 at posedge): pc=RESET_PC, state=FETCH, outValid=0, outInsMem=NOP, outAdd=0, outJump=0, pendPc=0, hold regs=0. outMemReq=1 in first cycle after reset.
- Reset mid-DRAIN/HOLD: abandons everything; outstanding response arriving after reset is accepted as the RESET_PC fetch only if memory honours the new address (memory must be reset together).
- Zero-wait memory: one instruction per cycle; outputs valid the edge after inMemReady.
- N wait cycles: N bubbles (outValid=0) unless stalled.
- Redirect latency: first request to target issued the cycle after redirect (FETCH/HOLD) or the cycle after the drained response (DRAIN).

## Structure
- Shared defines file: state encodings, NOP, RESET_PC default, jump-target bit slice widths.
- One natural sub-module: add4 (32-bit PC+4 incrementer), instantiated once.

## Test plan
- Reset, zero-wait memory returning addr as data -> outValid=1 with outAdd 4,8,12 and outInsMem 0,4,8 on consecutive cycles.
- Memory 2 wait cycles, no stall -> two outValid=0 cycles between each instruction; outMemAddr stable during wait.
- inStall asserted when inMemReady=1 for 3 cycles -> outputs frozen, outMemReq=0 in HOLD, held word presented on the edge after inStall drops.
- inJumpTaken (target 32'h0000_0400) while request waiting -> DRAIN, old data discarded, next request addr 0x400, outValid=0 during flush.
- inBranchTaken (0x100) and inJumpTaken (0x200) same cycle, inStall=1 -> next addr 0x100, outValid=0.
- pc=32'hFFFF_FFFC fetch -> outAdd=0, next request addr 0; outJump = {4'h0, instr[25:0], 2'b00}.
